// File: rtl/sprite_pkg.sv
// Shared constants and channel state type for the sprite engine.
// Optional horizontal mirroring is enabled by defining SPRITE_MIRROR_EN.
package sprite_pkg;

  localparam int DEF_NUM_SPRITES = 4;
  localparam int DEF_COORD_W     = 10;
  localparam int DEF_SPRITE_W    = 16;
  localparam int DEF_SPRITE_H    = 16;
  localparam int DEF_NUM_FRAMES  = 4;
  localparam int DEF_ANIM_DIV    = 8;
  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_V_ACTIVE    = 480;

  localparam int DEF_DIV_W   = $clog2(DEF_ANIM_DIV);
  localparam int DEF_FRAME_W = $clog2(DEF_NUM_FRAMES);

  localparam logic [1:0] TRANSPARENT = 2'b00;

  typedef struct packed {
    logic [DEF_COORD_W-1:0] pos_h;
    logic [DEF_COORD_W-1:0] pos_v;
    logic [DEF_COORD_W-1:0] sh_h;
    logic [DEF_COORD_W-1:0] sh_v;
    logic [DEF_DIV_W-1:0]   div;
    logic [DEF_FRAME_W-1:0] frame;
  } chan_state_t;

endpackage

// File: rtl/sprite_channel.sv
// One sprite channel: shadow/live position, write clamp, animation counter, hit test.
// With SPRITE_MIRROR_EN defined, i_mirror flips the column index of this channel.
module sprite_channel
  import sprite_pkg::*;
#(
  parameter int COORD_W    = DEF_COORD_W,
  parameter int SPRITE_W   = DEF_SPRITE_W,
  parameter int SPRITE_H   = DEF_SPRITE_H,
  parameter int NUM_FRAMES = DEF_NUM_FRAMES,
  parameter int ANIM_DIV   = DEF_ANIM_DIV,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int V_ACTIVE   = DEF_V_ACTIVE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_frame_start,
  input  logic                          i_wr_en,
  input  logic [COORD_W-1:0]            i_wr_h,
  input  logic [COORD_W-1:0]            i_wr_v,
  input  logic                          i_move_en,
  input  logic [COORD_W-1:0]            i_hcount,
  input  logic [COORD_W-1:0]            i_vcount,
`ifdef SPRITE_MIRROR_EN
  input  logic                          i_mirror,
`endif
  output logic                          o_hit,
  output logic [$clog2(SPRITE_W)-1:0]   o_dx,
  output logic [$clog2(SPRITE_H)-1:0]   o_dy,
  output logic [$clog2(NUM_FRAMES)-1:0] o_frame
);

  localparam int XW = $clog2(SPRITE_W);
  localparam int YW = $clog2(SPRITE_H);
  localparam int DW = $clog2(ANIM_DIV);
  localparam logic [COORD_W-1:0] H_LIM = COORD_W'(H_ACTIVE - SPRITE_W);
  localparam logic [COORD_W-1:0] V_LIM = COORD_W'(V_ACTIVE - SPRITE_H);

  chan_state_t        r_st;
  logic [COORD_W-1:0] w_cl_h, w_cl_v;
  logic [COORD_W-1:0] w_dx_full, w_dy_full;
  logic [XW-1:0]      w_dx;

  assign w_cl_h = (i_wr_h > H_LIM) ? H_LIM : i_wr_h;
  assign w_cl_v = (i_wr_v > V_LIM) ? V_LIM : i_wr_v;

  // Live takes the pre-edge shadow, so a coincident write lands one frame later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_st <= '0;
    end else begin
      if (i_frame_start) begin
        r_st.pos_h <= r_st.sh_h;
        r_st.pos_v <= r_st.sh_v;
        if (i_move_en) begin
          if (r_st.div == DW'(ANIM_DIV - 1)) begin
            r_st.div   <= '0;
            r_st.frame <= r_st.frame + 1'b1;
          end else begin
            r_st.div <= r_st.div + 1'b1;
          end
        end
      end
      if (i_wr_en) begin
        r_st.sh_h <= w_cl_h;
        r_st.sh_v <= w_cl_v;
      end
    end
  end

  // Modular subtraction: rasters left of/above the sprite wrap to large values and miss.
  assign w_dx_full = i_hcount - r_st.pos_h;
  assign w_dy_full = i_vcount - r_st.pos_v;
  assign o_hit     = (w_dx_full < COORD_W'(SPRITE_W)) && (w_dy_full < COORD_W'(SPRITE_H));
  assign w_dx      = w_dx_full[XW-1:0];
  assign o_dy      = w_dy_full[YW-1:0];
  assign o_frame   = r_st.frame;

`ifdef SPRITE_MIRROR_EN
  assign o_dx = i_mirror ? (XW'(SPRITE_W - 1) - w_dx) : w_dx;
`else
  assign o_dx = w_dx;
`endif

endmodule

// File: rtl/sprite_engine.sv
// Multi-channel sprite engine: priority hit test, ROM address stage, pixel select stage.
// Define SPRITE_MIRROR_EN to add the per-sprite mirror input.
module sprite_engine
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = DEF_NUM_SPRITES,
  parameter int COORD_W     = DEF_COORD_W,
  parameter int SPRITE_W    = DEF_SPRITE_W,
  parameter int SPRITE_H    = DEF_SPRITE_H,
  parameter int NUM_FRAMES  = DEF_NUM_FRAMES,
  parameter int ANIM_DIV    = DEF_ANIM_DIV,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE
) (
  input  logic                                                       clk,
  input  logic                                                       reset,
  input  logic [COORD_W-1:0]                                         hcount,
  input  logic [COORD_W-1:0]                                         vcount,
  input  logic                                                       frame_start,
  input  logic                                                       wr_en,
  input  logic [$clog2(NUM_SPRITES)-1:0]                             wr_sel,
  input  logic [COORD_W-1:0]                                         wr_h,
  input  logic [COORD_W-1:0]                                         wr_v,
  input  logic [NUM_SPRITES-1:0]                                     move_en,
`ifdef SPRITE_MIRROR_EN
  input  logic [NUM_SPRITES-1:0]                                     mirror,
`endif
  output logic [$clog2(NUM_SPRITES*NUM_FRAMES*SPRITE_W*SPRITE_H)-1:0] rom_addr,
  input  logic [1:0]                                                 rom_data,
  output logic [1:0]                                                 pixel_out,
  output logic [$clog2(NUM_SPRITES)-1:0]                             sprite_id
);

  localparam int ID_W   = $clog2(NUM_SPRITES);
  localparam int XW     = $clog2(SPRITE_W);
  localparam int YW     = $clog2(SPRITE_H);
  localparam int FW     = $clog2(NUM_FRAMES);
  localparam int AW     = $clog2(NUM_SPRITES*NUM_FRAMES*SPRITE_W*SPRITE_H);
  localparam int STAGES = 2;

  logic [NUM_SPRITES-1:0]         w_hit;
  logic [NUM_SPRITES-1:0][XW-1:0] w_dx;
  logic [NUM_SPRITES-1:0][YW-1:0] w_dy;
  logic [NUM_SPRITES-1:0][FW-1:0] w_frame;

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_ch
    sprite_channel #(
      .COORD_W    (COORD_W),
      .SPRITE_W   (SPRITE_W),
      .SPRITE_H   (SPRITE_H),
      .NUM_FRAMES (NUM_FRAMES),
      .ANIM_DIV   (ANIM_DIV),
      .H_ACTIVE   (H_ACTIVE),
      .V_ACTIVE   (V_ACTIVE)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .i_frame_start (frame_start),
      .i_wr_en       (wr_en && (wr_sel == ID_W'(g))),
      .i_wr_h        (wr_h),
      .i_wr_v        (wr_v),
      .i_move_en     (move_en[g]),
      .i_hcount      (hcount),
      .i_vcount      (vcount),
`ifdef SPRITE_MIRROR_EN
      .i_mirror      (mirror[g]),
`endif
      .o_hit         (w_hit[g]),
      .o_dx          (w_dx[g]),
      .o_dy          (w_dy[g]),
      .o_frame       (w_frame[g])
    );
  end

  logic            w_win_hit;
  logic [ID_W-1:0] w_win_id;
  logic [AW-1:0]   w_win_addr;

  // Scan high to low so the lowest hitting index is the last assignment.
  always_comb begin
    w_win_hit  = 1'b0;
    w_win_id   = '0;
    w_win_addr = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_win_hit  = 1'b1;
        w_win_id   = ID_W'(i);
        w_win_addr = {ID_W'(i), w_frame[i], w_dy[i], w_dx[i]};
      end
    end
  end

  logic [STAGES:1] r_vld_pipe;
  logic [AW-1:0]   r_rom_addr;
  logic [ID_W-1:0] r_id1, r_id2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld_pipe <= '0;
      r_rom_addr <= '0;
      r_id1      <= '0;
      r_id2      <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[1], w_win_hit};
      r_rom_addr <= w_win_addr;
      r_id1      <= w_win_id;
      r_id2      <= r_id1;
    end
  end

  assign rom_addr  = r_rom_addr;
  assign sprite_id = r_id2;
  // ROM data lines up with stage 2; a transparent winner still masks lower channels.
  assign pixel_out = r_vld_pipe[STAGES] ? rom_data : TRANSPARENT;

endmodule

// File: tb/tb_sprite_engine.sv
// Self-checking bench for sprite_engine with an event-level reference model and a synchronous ROM.
module tb_sprite_engine;

  localparam int NS = 4, CW = 10, SW = 16, SH = 16, NF = 4, AD = 8, HA = 640, VA = 480;
  localparam int MASK = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] hcount, vcount, wr_h, wr_v;
  logic          frame_start, wr_en;
  logic [1:0]    wr_sel;
  logic [NS-1:0] move_en;
  logic [11:0]   rom_addr;
  logic [1:0]    rom_data, pixel_out, sprite_id;
`ifdef SPRITE_MIRROR_EN
  logic [NS-1:0] mirror;
`endif

  int checks = 0;
  int errors = 0;

  int live_h[NS], live_v[NS], sh_h[NS], sh_v[NS], nmov[NS];
  bit e1_hit, e2_hit;
  int e1_id, e1_addr, e2_id, e2_addr;

  always #5 clk = ~clk;

  sprite_engine #(
    .NUM_SPRITES(NS), .COORD_W(CW), .SPRITE_W(SW), .SPRITE_H(SH),
    .NUM_FRAMES(NF), .ANIM_DIV(AD), .H_ACTIVE(HA), .V_ACTIVE(VA)
  ) dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .frame_start(frame_start), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_h(wr_h), .wr_v(wr_v), .move_en(move_en),
`ifdef SPRITE_MIRROR_EN
    .mirror(mirror),
`endif
    .rom_addr(rom_addr), .rom_data(rom_data),
    .pixel_out(pixel_out), .sprite_id(sprite_id)
  );

  function automatic logic [1:0] rom_fn(input int a);
    return 2'((a ^ (a >> 3) ^ (a >> 7)) + 1);
  endfunction

  always @(posedge clk) rom_data <= rom_fn(int'(rom_addr));

  function automatic int clamp(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin
      live_h[i] = 0; live_v[i] = 0; sh_h[i] = 0; sh_v[i] = 0; nmov[i] = 0;
    end
    e1_hit = 0; e2_hit = 0; e1_id = 0; e2_id = 0; e1_addr = 0; e2_addr = 0;
  endfunction

  function automatic void model_eval(input int h, input int v, output bit hit,
                                     output int id, output int addr);
    hit = 0; id = 0; addr = 0;
    for (int i = 0; i < NS; i++) begin
      int dx, dy;
      dx = (h - live_h[i]) & MASK;
      dy = (v - live_v[i]) & MASK;
      if (!hit && dx < SW && dy < SH) begin
`ifdef SPRITE_MIRROR_EN
        if (mirror[i]) dx = SW - 1 - dx;
`endif
        hit  = 1;
        id   = i;
        addr = ((i * NF + (nmov[i] / AD) % NF) * SH + dy) * SW + dx;
      end
    end
  endfunction

  // One clock: evaluate the raster against pre-edge state, then apply this edge's events.
  task automatic tick();
    bit h; int id, a;
    model_eval(int'(hcount), int'(vcount), h, id, a);
    @(posedge clk);
    e2_hit = e1_hit; e2_id = e1_id; e2_addr = e1_addr;
    e1_hit = h;      e1_id = id;    e1_addr = a;
    if (frame_start)
      for (int i = 0; i < NS; i++) begin
        live_h[i] = sh_h[i]; live_v[i] = sh_v[i];
        if (move_en[i]) nmov[i]++;
      end
    if (wr_en) begin
      sh_h[int'(wr_sel)] = clamp(int'(wr_h), HA - SW);
      sh_v[int'(wr_sel)] = clamp(int'(wr_v), VA - SH);
    end
    #1;
  endtask

  task automatic write_pos(input int sel, input int h, input int v);
    wr_en = 1; wr_sel = 2'(sel); wr_h = CW'(h); wr_v = CW'(v);
    tick();
    wr_en = 0;
  endtask

  task automatic pulse_fs();
    frame_start = 1; tick(); frame_start = 0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (rom_addr !== 12'd0) begin errors++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
    checks++; if (pixel_out !== 2'b00) begin errors++; $display("FAIL reset_pixel got %0d want 0", pixel_out); end
    checks++; if (sprite_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d want 0", sprite_id); end
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1;
  endtask

  task automatic test_position();
    logic [1:0] ep;
    write_pos(0, 150, 390);
    pulse_fs();
    hcount = 150; vcount = 390;
    tick();
    checks++; if (rom_addr !== 12'd0 || !e1_hit) begin errors++; $display("FAIL hit_addr got %0d want 0", rom_addr); end
    hcount = 166;
    tick();
    ep = rom_fn(0);
    checks++; if (pixel_out !== ep) begin errors++; $display("FAIL hit_pixel got %0d want %0d", pixel_out, ep); end
    checks++; if (sprite_id !== 2'd0) begin errors++; $display("FAIL hit_id got %0d want 0", sprite_id); end
    tick();
    checks++; if (pixel_out !== 2'b00 || e2_hit) begin errors++; $display("FAIL edge_miss_pixel got %0d want 0", pixel_out); end
    write_pos(1, 150, 390);
    pulse_fs();
    hcount = 155; vcount = 395;
    tick();
    checks++; if (rom_addr !== 12'd85) begin errors++; $display("FAIL overlap_addr got %0d want 85", rom_addr); end
    tick();
    checks++; if (sprite_id !== 2'd0) begin errors++; $display("FAIL overlap_id got %0d want 0", sprite_id); end
    ep = rom_fn(85);
    checks++; if (pixel_out !== ep) begin errors++; $display("FAIL overlap_pixel got %0d want %0d", pixel_out, ep); end
  endtask

  task automatic test_clamp();
    write_pos(2, 700, 470);
    hcount = 624; vcount = 464;
    tick(); tick();
    checks++; if (pixel_out !== 2'b00) begin errors++; $display("FAIL shadow_not_live got %0d want 0", pixel_out); end
    pulse_fs();
    tick();
    checks++; if (rom_addr !== 12'd2048) begin errors++; $display("FAIL clamp_addr got %0d want 2048", rom_addr); end
    tick();
    checks++; if (sprite_id !== 2'd2) begin errors++; $display("FAIL clamp_id got %0d want 2", sprite_id); end
    hcount = 623;
    tick(); tick();
    checks++; if (pixel_out !== 2'b00) begin errors++; $display("FAIL clamp_left_miss got %0d want 0", pixel_out); end
    // write and frame_start together: live keeps the old shadow (0,0)
    wr_en = 1; wr_sel = 2'd3; wr_h = 10; wr_v = 10; frame_start = 1;
    tick();
    wr_en = 0; frame_start = 0;
    hcount = 0; vcount = 0;
    tick();
    checks++; if (rom_addr !== 12'd3072) begin errors++; $display("FAIL coincide_old got %0d want 3072", rom_addr); end
    pulse_fs();
    hcount = 10; vcount = 10;
    tick();
    checks++; if (rom_addr !== 12'd3072) begin errors++; $display("FAIL coincide_new got %0d want 3072", rom_addr); end
    hcount = 0; vcount = 0;
    tick(); tick();
    checks++; if (pixel_out !== 2'b00 || e2_hit) begin errors++; $display("FAIL coincide_moved got %0d want 0", pixel_out); end
  endtask

  task automatic test_anim();
    move_en = 4'b0001;
    hcount = 150; vcount = 390;
    for (int p = 1; p <= 32; p++) begin
      pulse_fs();
      tick();
      checks++; if (rom_addr !== 12'(e1_addr)) begin errors++; $display("FAIL anim_p%0d got %0d want %0d", p, rom_addr, e1_addr); end
      if (p == 8) begin
        checks++; if (rom_addr[9:8] !== 2'd1) begin errors++; $display("FAIL anim_step got %0d want 1", rom_addr[9:8]); end
      end
      if (p == 32) begin
        checks++; if (rom_addr[9:8] !== 2'd0) begin errors++; $display("FAIL anim_wrap got %0d want 0", rom_addr[9:8]); end
      end
    end
    move_en = '0;
  endtask

  task automatic test_random();
    int k;
    logic [1:0] ep;
    for (int n = 0; n < 1500; n++) begin
      wr_en = ($urandom_range(0, 3) == 0);
      wr_sel = 2'($urandom_range(0, 3));
      wr_h = CW'($urandom_range(0, 700));
      wr_v = CW'($urandom_range(0, 520));
      frame_start = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) move_en = NS'($urandom);
`ifdef SPRITE_MIRROR_EN
      if ($urandom_range(0, 49) == 0) mirror = NS'($urandom);
`endif
      if ($urandom_range(0, 4) == 0) begin
        hcount = CW'($urandom); vcount = CW'($urandom);
      end else begin
        k = $urandom_range(0, NS - 1);
        hcount = CW'(live_h[k] + int'($urandom_range(0, 19)) - 2);
        vcount = CW'(live_v[k] + int'($urandom_range(0, 19)) - 2);
      end
      tick();
      if (e1_hit) begin
        checks++; if (rom_addr !== 12'(e1_addr)) begin errors++; $display("FAIL rand_addr n=%0d got %0d want %0d", n, rom_addr, e1_addr); end
      end
      ep = e2_hit ? rom_fn(e2_addr) : 2'b00;
      checks++; if (pixel_out !== ep) begin errors++; $display("FAIL rand_pixel n=%0d got %0d want %0d", n, pixel_out, ep); end
      if (e2_hit) begin
        checks++; if (sprite_id !== 2'(e2_id)) begin errors++; $display("FAIL rand_id n=%0d got %0d want %0d", n, sprite_id, e2_id); end
      end
    end
    wr_en = 0; frame_start = 0; move_en = '0;
  endtask

  task automatic test_reset_mid();
    logic [1:0] ep;
`ifdef SPRITE_MIRROR_EN
    mirror = '0;
`endif
    write_pos(0, 150, 390);
    pulse_fs();
    move_en = 4'b0001;
    repeat (5) pulse_fs();
    write_pos(1, 300, 200);
    hcount = 150; vcount = 390;
    tick(); tick();
    #2 reset = 0;
    #1;
    checks++; if (rom_addr !== 12'd0) begin errors++; $display("FAIL midreset_addr got %0d want 0", rom_addr); end
    checks++; if (pixel_out !== 2'b00) begin errors++; $display("FAIL midreset_pixel got %0d want 0", pixel_out); end
    checks++; if (sprite_id !== 2'd0) begin errors++; $display("FAIL midreset_id got %0d want 0", sprite_id); end
    model_reset();
    @(negedge clk); reset = 1;
    hcount = 0; vcount = 0;
    tick();
    checks++; if (rom_addr !== 12'd0) begin errors++; $display("FAIL postreset_frame got %0d want 0", rom_addr); end
    for (int p = 1; p <= 8; p++) begin
      pulse_fs();
      tick();
      if (p == 3) begin
        checks++; if (rom_addr !== 12'd0) begin errors++; $display("FAIL divider_cleared got %0d want 0", rom_addr); end
      end
      if (p == 8) begin
        checks++; if (rom_addr !== 12'd256) begin errors++; $display("FAIL postreset_step got %0d want 256", rom_addr); end
      end
    end
    move_en = '0;
    hcount = 300; vcount = 200;
    tick(); tick();
    ep = e2_hit ? rom_fn(e2_addr) : 2'b00;
    checks++; if (pixel_out !== 2'b00 || pixel_out !== ep) begin errors++; $display("FAIL shadow_discarded got %0d want 0", pixel_out); end
`ifdef SPRITE_MIRROR_EN
    mirror = 4'b0001;
    hcount = 3; vcount = 0;
    tick();
    checks++; if (rom_addr[3:0] !== 4'd12) begin errors++; $display("FAIL mirror_col got %0d want 12", rom_addr[3:0]); end
    mirror = '0;
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 0; hcount = 0; vcount = 0; frame_start = 0; wr_en = 0;
    wr_sel = 0; wr_h = 0; wr_v = 0; move_en = '0;
`ifdef SPRITE_MIRROR_EN
    mirror = '0;
`endif
    model_reset();
    test_reset();
    test_position();
    test_clamp();
    test_anim();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
